// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input, program-memory write port and CPU control/status of the boot loader.
interface prog_loader_if #(parameter int ADDR_W = 8);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              err_clr;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [7:0]        pm_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [1:0]        err_code;
    modport master (
        output in_data, in_valid, err_clr,
        input  in_ready, pm_we, pm_addr, pm_wdata, cpu_hold, load_done, load_err, err_code
    );
    modport slave (
        input  in_data, in_valid, err_clr,
        output in_ready, pm_we, pm_addr, pm_wdata, cpu_hold, load_done, load_err, err_code
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: parses A5/len/payload/checksum frames into program memory and holds the CPU until a good frame lands.
module prog_loader #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input logic         clk,
    input logic         reset,
    prog_loader_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    localparam int         TW   = $clog2(TIMEOUT + 1);
    localparam logic [9:0] DMAX = 10'(DEPTH);

    state_t            r_state, w_nxt;
    logic              r_ready, r_we, r_hold, r_done, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata, r_sum;
    logic [1:0]        r_code, w_code;
    logic [8:0]        r_cnt, r_len, w_len;
    logic [TW-1:0]     r_tmo;
    logic              w_acc, w_hdr, w_active, w_tmo_hit, w_wr;

    assign w_acc     = bus.in_valid & r_ready;
    assign w_hdr     = w_acc && bus.in_data == 8'hA5;
    assign w_len     = bus.in_data == 8'h00 ? 9'd256 : {1'b0, bus.in_data};
    assign w_active  = r_state inside {S_LEN, S_DATA, S_CSUM};
    assign w_tmo_hit = w_active && !w_acc && r_tmo == TW'(TIMEOUT - 1);
    assign w_wr      = r_state == S_DATA && w_acc;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_nxt = w_hdr ? S_LEN : r_state;
            S_LEN:  w_nxt = w_tmo_hit ? S_ERR : !w_acc ? S_LEN : {1'b0, w_len} > DMAX ? S_ERR : S_DATA;
            S_DATA: w_nxt = w_tmo_hit ? S_ERR : (w_acc && r_cnt == r_len - 9'd1) ? S_CSUM : S_DATA;
            S_CSUM: w_nxt = w_tmo_hit ? S_ERR : !w_acc ? S_CSUM : bus.in_data == r_sum ? S_DONE : S_ERR;
            S_ERR:  w_nxt = bus.err_clr ? S_IDLE : S_ERR;
            default: w_nxt = S_IDLE;
        endcase
    end

    // the error cause is latched on the transition into ERROR and held there
    always_comb begin
        w_code = w_nxt != S_ERR ? 2'b00 : r_state == S_ERR ? r_code :
                 w_tmo_hit ? 2'b10 : r_state == S_LEN ? 2'b11 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= 2'b00;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_tmo   <= '0;
        end else begin
            r_ready <= w_nxt != S_ERR;
            r_we    <= w_wr;
            r_hold  <= w_nxt != S_DONE;
            r_done  <= w_nxt == S_DONE;
            r_err   <= w_nxt == S_ERR;
            r_code  <= w_code;
            if (w_wr) begin
                r_addr  <= r_cnt[ADDR_W-1:0];
                r_wdata <= bus.in_data;
            end
            r_cnt <= r_state == S_LEN ? 9'd0 : w_wr ? r_cnt + 9'd1 : r_cnt;
            r_sum <= r_state == S_LEN ? 8'd0 : w_wr ? r_sum + bus.in_data : r_sum;
            if (r_state == S_LEN && w_acc) r_len <= w_len;
            r_tmo <= (!w_active || w_acc || w_nxt != r_state) ? '0 : r_tmo + TW'(1);
        end
    end

    assign bus.in_ready  = r_ready;
    assign bus.pm_we     = r_we;
    assign bus.pm_addr   = r_addr;
    assign bus.pm_wdata  = r_wdata;
    assign bus.cpu_hold  = r_hold;
    assign bus.load_done = r_done;
    assign bus.load_err  = r_err;
    assign bus.err_code  = r_code;
endmodule
